hsv_core_branch_resolve_pipe: RTL
=================================

Name: hsv_core_branch_resolve_pipe

Overview:
Parametrised branch resolution pipeline for the hsv_core branch unit. Each accepted branch/jump gets its condition and target evaluated, and its registered result is compared against the front-end prediction. The stage emits a redirect on misprediction, flags misaligned targets, and keeps resolved/mispredict counters. It sits between branch issue and commit, uses valid/ready handshakes with per-stage bubble collapsing, and has configurable XLEN and pipeline depth.

Parameters:
XLEN, 32, datapath width (32 or 64)
STAGES, 2, register stages from accept to valid_o (1..4)
COMPRESSED, 0, 1 = 2-byte instruction alignment (C extension), 0 = 4-byte
TAG_W, 4, width of opaque instruction tag passed through
CNT_W, 32, performance counter width

Ports:
clk_core  in  1  core clock
rst_core_n  in  1  asynchronous active-low reset
flush_req  in  1  kill all in-flight entries
valid_i  in  1  input entry valid
ready_o  out  1  stage can accept input this cycle
rs1_i / rs2_i  in  XLEN  operands
pc_i  in  XLEN  branch PC
imm_i  in  XLEN  sign-extended immediate
relative_i  in  1  1: target base = pc_i, 0: base = rs1_i (JALR)
cond_lt_i  in  1  0: equal compare, 1: less-than compare
cond_signed_i  in  1  signed less-than
negate_i  in  1  invert condition
unconditional_i  in  1  force taken
pred_taken_i  in  1  predicted direction
pred_target_i  in  XLEN  predicted target
tag_i  in  TAG_W  instruction tag
valid_o  out  1  result valid
ready_i  in  1  downstream accepts
taken_o  out  1  resolved direction
target_o  out  XLEN  resolved target
next_pc_o  out  XLEN  taken ? target : pc+4
mispredict_o  out  1  prediction wrong
misaligned_o  out  1  taken and target misaligned
tag_o  out  TAG_W  tag of output entry
redirect_valid_o  out  1  one-cycle redirect pulse
redirect_pc_o  out  XLEN  fetch restart PC
cnt_resolved_o  out  CNT_W  branches retired through the stage
cnt_mispredict_o  out  CNT_W  mispredicted branches

Behaviour:
- Reset (async, rst_core_n low): all stage valids 0, both counters 0. valid_o, redirect_valid_o, mispredict_o, misaligned_o and taken_o read 0. Data registers are don't-care.
- Evaluation is combinational at input and captured into stage 0.
  - Less-than: (XLEN+1)-bit subtract with MSBs XORed by cond_signed_i; borrow = lt.
  - taken = unconditional_i | (negate_i ^ (cond_lt_i ? lt : eq)).
  - target = base + imm_i, modulo 2^XLEN. When relative_i=0, bit 0 is cleared.
  - fallthrough = pc_i + 4, wraps.
- Mispredict = (taken != pred_taken_i) | (taken & target != pred_target_i). This is computed at input and carried through the stages.
- misaligned = taken & ~COMPRESSED & target[1] (bit 0 is always 0 for taken targets).
- Stages 0..STAGES-1 form a shift pipeline. Stage k advances when valid and (k==last ? ready_i : next empty or advancing).
  - ready_o = ~v[0] | adv[0]; accept = valid_i & ready_o.
  - Latency is exactly STAGES cycles with ready_i=1. Throughput is 1 per cycle.
  - Bubbles collapse under backpressure. An entry is never dropped or duplicated.
- Outputs come straight from the last stage registers.
- fire = valid_o & ready_i & ~flush_req.
- redirect_valid_o = fire & (mispredict | misaligned). This output is combinational.
  - redirect_pc_o = next_pc_o on mispredict.
  - On misaligned, redirect_pc_o is still driven but commit raises the trap; misaligned wins.
- Counters:
  - cnt_resolved_o increments on fire.
  - cnt_mispredict_o increments on fire & mispredict & ~misaligned.
  - Both wrap at 2^CNT_W and are unaffected by flush.
- flush_req: next cycle all valids = 0.
  - Same-cycle accept is discarded.
  - Same-cycle output is not counted and gives no redirect.
  - flush_req has priority over everything except reset.
- Reset mid-operation: everything in flight is lost. Counters clear.

Decomposition:
- hsv_core_pkg gains a branch_resolve_t payload (taken, target, next_pc, mispredict, misaligned, tag), parametrised via XLEN-sized word types, plus constant INSN_BYTES=4.
- Natural sub-module: hsv_core_branch_eval, the combinational condition/target/mispredict evaluator instantiated at the pipeline input. Its outputs feed the stage registers.

Test Plan:
- BEQ, STAGES=2, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120, ready_i=1 -> valid_o 2 cycles later, taken=1, target=0x120, mispredict=0, no redirect, cnt_resolved=1.
- BLT signed, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken=1, mispredict=1, redirect_valid_o pulse with redirect_pc_o=pc+imm, cnt_mispredict=1. Same operands as BLTU -> taken=0, no redirect.
- JALR relative_i=0, rs1=0x1003, imm=0, COMPRESSED=0 -> target=0x1002, misaligned=1, redirect_valid_o=1, cnt_mispredict unchanged.
- Backpressure: 5 back-to-back entries, ready_i=0 for 4 cycles -> ready_o drops after STAGES entries held; all 5 emerge in order with tags 0..4 once ready_i=1.
- flush_req asserted with 2 entries in flight and valid_o & ready_i high -> next cycle valid_o=0, no redirect, counters unchanged.
- Wrap: pc=0xFFFFFFFC, not taken -> next_pc_o=0. With CNT_W=4, after 16 fires cnt_resolved_o=0.

Source files
------------

// File: rtl/hsv_core_branch_resolve_pipe_pkg.sv
// Shared constants and helpers for the hsv_core branch resolution pipeline.
// Payload structs are XLEN-dependent and therefore live in the modules.
package hsv_core_branch_resolve_pipe_pkg;

    localparam int INSN_BYTES = 4;
    localparam int MAX_STAGES = 4;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_MISPREDICT,
        REDIR_MISALIGNED
    } redirect_cause_e;

    // A misaligned target is a trap at commit, so it outranks a plain mispredict.
    function automatic redirect_cause_e redirect_cause(input logic mispredict,
                                                       input logic misaligned);
        if (misaligned) return REDIR_MISALIGNED;
        if (mispredict) return REDIR_MISPREDICT;
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/hsv_core_branch_resolve_pipe_if.sv
// Issue-side request and commit-side result bus of the branch resolve pipe.
// The slave modport is the pipeline's view, master is the environment's view.
interface hsv_core_branch_resolve_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             valid_i;
    logic             ready_o;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  imm_i;
    logic             relative_i;
    logic             cond_lt_i;
    logic             cond_signed_i;
    logic             negate_i;
    logic             unconditional_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  pred_target_i;
    logic [TAG_W-1:0] tag_i;

    logic             valid_o;
    logic             ready_i;
    logic             taken_o;
    logic [XLEN-1:0]  target_o;
    logic [XLEN-1:0]  next_pc_o;
    logic             mispredict_o;
    logic             misaligned_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  valid_i, rs1_i, rs2_i, pc_i, imm_i, relative_i, cond_lt_i,
               cond_signed_i, negate_i, unconditional_i, pred_taken_i,
               pred_target_i, tag_i, ready_i,
        output ready_o, valid_o, taken_o, target_o, next_pc_o, mispredict_o,
               misaligned_o, tag_o
    );

    modport master (
        output valid_i, rs1_i, rs2_i, pc_i, imm_i, relative_i, cond_lt_i,
               cond_signed_i, negate_i, unconditional_i, pred_taken_i,
               pred_target_i, tag_i, ready_i,
        input  ready_o, valid_o, taken_o, target_o, next_pc_o, mispredict_o,
               misaligned_o, tag_o
    );

endinterface

// File: rtl/hsv_core_branch_resolve_pipe_eval.sv
// Combinational branch evaluator: condition, target, fall-through PC,
// mispredict and misalignment, all computed from the incoming request.
module hsv_core_branch_resolve_pipe_eval
    import hsv_core_branch_resolve_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int COMPRESSED = 0
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            relative_i,
    input  logic            cond_lt_i,
    input  logic            cond_signed_i,
    input  logic            negate_i,
    input  logic            unconditional_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            mispredict_o,
    output logic            misaligned_o
);

    logic [XLEN:0]   lhs, rhs, diff;
    logic [XLEN-1:0] base, sum;
    logic            lt, eq;

    always_comb begin
        // Flipping the sign bits turns a signed compare into an unsigned one;
        // the borrow out of the widened subtract is then the less-than result.
        lhs  = {1'b0, rs1_i[XLEN-1] ^ cond_signed_i, rs1_i[XLEN-2:0]};
        rhs  = {1'b0, rs2_i[XLEN-1] ^ cond_signed_i, rs2_i[XLEN-2:0]};
        diff = lhs - rhs;
        lt   = diff[XLEN];
        eq   = (rs1_i == rs2_i);

        taken_o   = unconditional_i | (negate_i ^ (cond_lt_i ? lt : eq));
        base      = relative_i ? pc_i : rs1_i;
        sum       = base + imm_i;
        target_o  = relative_i ? sum : {sum[XLEN-1:1], 1'b0};
        next_pc_o = taken_o ? target_o : pc_i + XLEN'(INSN_BYTES);

        mispredict_o = (taken_o != pred_taken_i) |
                       (taken_o & (target_o != pred_target_i));
        misaligned_o = taken_o & (COMPRESSED == 0) & target_o[1];
    end

endmodule

// File: rtl/hsv_core_branch_resolve_pipe.sv
// Branch resolution pipeline: evaluate at accept, carry the result through
// STAGES collapsing register stages, then emit redirect and count retirements.
module hsv_core_branch_resolve_pipe
    import hsv_core_branch_resolve_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STAGES     = 2,
    parameter int COMPRESSED = 0,
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_core,
    input  logic                  rst_core_n,
    input  logic                  flush_req,
    hsv_core_branch_resolve_pipe_if.slave bus,
    output logic                  redirect_valid_o,
    output logic [XLEN-1:0]       redirect_pc_o,
    output logic [CNT_W-1:0]      cnt_resolved_o,
    output logic [CNT_W-1:0]      cnt_mispredict_o
);

    typedef struct packed {
        logic             taken;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  next_pc;
        logic             mispredict;
        logic             misaligned;
        logic [TAG_W-1:0] tag;
    } branch_resolve_t;

    logic            ev_taken, ev_mispredict, ev_misaligned;
    logic [XLEN-1:0] ev_target, ev_next_pc;
    branch_resolve_t eval_res;

    hsv_core_branch_resolve_pipe_eval #(
        .XLEN       (XLEN),
        .COMPRESSED (COMPRESSED)
    ) u_eval (
        .rs1_i           (bus.rs1_i),
        .rs2_i           (bus.rs2_i),
        .pc_i            (bus.pc_i),
        .imm_i           (bus.imm_i),
        .relative_i      (bus.relative_i),
        .cond_lt_i       (bus.cond_lt_i),
        .cond_signed_i   (bus.cond_signed_i),
        .negate_i        (bus.negate_i),
        .unconditional_i (bus.unconditional_i),
        .pred_taken_i    (bus.pred_taken_i),
        .pred_target_i   (bus.pred_target_i),
        .taken_o         (ev_taken),
        .target_o        (ev_target),
        .next_pc_o       (ev_next_pc),
        .mispredict_o    (ev_mispredict),
        .misaligned_o    (ev_misaligned)
    );

    assign eval_res = '{taken: ev_taken, target: ev_target, next_pc: ev_next_pc,
                        mispredict: ev_mispredict, misaligned: ev_misaligned,
                        tag: bus.tag_i};

    logic [STAGES-1:0] v_q, v_d, adv;
    branch_resolve_t   data_q [STAGES];
    branch_resolve_t   data_d [STAGES];
    logic              sink_ok, accept, fire;
    logic [CNT_W-1:0]  cnt_resolved_q, cnt_resolved_d;
    logic [CNT_W-1:0]  cnt_mispredict_q, cnt_mispredict_d;
    redirect_cause_e   cause;

    // Walk from the output back to the input: a stage may move if its
    // successor is empty or itself moving this cycle.
    always_comb begin
        // NOTE: blocking '=' is correct here; sink_ok is a ripple temporary
        // whose new value must be seen by the next loop iteration.
        adv     = '0;
        sink_ok = bus.ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = v_q[k] & sink_ok;
            sink_ok = ~v_q[k] | adv[k];
        end
        bus.ready_o = sink_ok;
        accept      = bus.valid_i & sink_ok;
    end

    always_comb begin
        // NOTE: every output gets a default before any condition, so no
        // path through this block leaves a variable unassigned (no latches).
        for (int k = 0; k < STAGES; k++) begin
            v_d[k]    = v_q[k] & ~adv[k];
            data_d[k] = data_q[k];
        end
        if (accept) begin
            v_d[0]    = 1'b1;
            data_d[0] = eval_res;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
                v_d[k]    = 1'b1;
                data_d[k] = data_q[k-1];
            end
        end
        if (flush_req) v_d = '0;
    end

    assign bus.valid_o      = v_q[STAGES-1];
    assign bus.taken_o      = v_q[STAGES-1] & data_q[STAGES-1].taken;
    assign bus.target_o     = data_q[STAGES-1].target;
    assign bus.next_pc_o    = data_q[STAGES-1].next_pc;
    assign bus.mispredict_o = v_q[STAGES-1] & data_q[STAGES-1].mispredict;
    assign bus.misaligned_o = v_q[STAGES-1] & data_q[STAGES-1].misaligned;
    assign bus.tag_o        = data_q[STAGES-1].tag;

    always_comb begin
        fire             = bus.valid_o & bus.ready_i & ~flush_req;
        cause            = redirect_cause(bus.mispredict_o, bus.misaligned_o);
        redirect_valid_o = fire & (cause != REDIR_NONE);
        redirect_pc_o    = bus.next_pc_o;
        cnt_resolved_d   = cnt_resolved_q;
        cnt_mispredict_d = cnt_mispredict_q;
        if (fire) cnt_resolved_d = cnt_resolved_q + CNT_W'(1);
        if (fire && cause == REDIR_MISPREDICT)
            cnt_mispredict_d = cnt_mispredict_q + CNT_W'(1);
    end

    assign cnt_resolved_o   = cnt_resolved_q;
    assign cnt_mispredict_o = cnt_mispredict_q;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            v_q              <= '0;
            cnt_resolved_q   <= '0;
            cnt_mispredict_q <= '0;
        end else begin
            v_q              <= v_d;
            cnt_resolved_q   <= cnt_resolved_d;
            cnt_mispredict_q <= cnt_mispredict_d;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed when the
    // matching valid bit is set, and the flags leaving the stage are gated.
    always_ff @(posedge clk_core) begin
        data_q <= data_d;
    end

endmodule
